// File: rtl/string_loader_pkg.sv
// rtl/string_loader_pkg.sv - shared constants and FSM state type for the string loader
package string_loader_pkg;

    localparam int CW     = 7;
    localparam int NCHARS = 11;
    localparam int STRW   = NCHARS * CW;

    // A NUL character marks end of string downstream, so it is never staged.
    localparam logic [CW-1:0] ASCII_NUL = '0;

    typedef enum logic [1:0] {
        IDLE,
        LOCK,
        PUB
    } state_t;

endpackage

// File: rtl/string_loader_lockout_timer.sv
// rtl/string_loader_lockout_timer.sv - down-counter spacing successive publish strobes
//
// Ports:
//   clk, rst  - clock, synchronous active-high reset
//   load      - reload the counter with LOCK_CYC-1
//   zero      - counter has reached zero (it holds there until reloaded)
module lockout_timer #(
    parameter int LOCK_CYC = 4096
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int W = $clog2(LOCK_CYC);
    localparam logic [W-1:0] RELOAD = W'(LOCK_CYC - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/string_loader.sv
// rtl/string_loader.sv - staging buffer for LCD characters with rate-limited publish
//
// Ports:
//   clk, rst              - clock, synchronous active-high reset
//   char_valid/char_in    - character offer; transfer when char_valid && char_ready
//   char_ready            - a free slot exists
//   backspace/clear       - staging edits (clear wins over backspace wins over char)
//   commit                - request to publish the staging buffer
//   String                - published string, slot 0 in the MSBs, zero padded
//   change                - one-cycle strobe in the cycle String takes a new value
//   count                 - number of staged characters
//   pend                  - a commit is waiting for the lockout to expire
module string_loader #(
    parameter int NCHARS   = string_loader_pkg::NCHARS,
    parameter int CW       = string_loader_pkg::CW,
    parameter int LOCK_CYC = 4096
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       char_valid,
    input  logic [CW-1:0]              char_in,
    output logic                       char_ready,
    input  logic                       backspace,
    input  logic                       clear,
    input  logic                       commit,
    output logic [NCHARS*CW-1:0]       String,
    output logic                       change,
    output logic [$clog2(NCHARS+1)-1:0] count,
    output logic                       pend
);

    import string_loader_pkg::*;

    localparam int CNT_W = $clog2(NCHARS + 1);
    localparam logic [CNT_W-1:0] FULL = CNT_W'(NCHARS);

    // Ascending slot range so the packed vector puts slot 0 in the MSBs.
    logic [0:NCHARS-1][CW-1:0] slots;

    state_t state, state_n;
    logic   do_pub;
    logic   set_pend;
    logic   lock_zero;

    assign char_ready = (count < FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            slots <= '0;
            count <= '0;
        end else if (clear) begin
            slots <= '0;
            count <= '0;
        end else if (backspace) begin
            if (count != '0) begin
                slots[count - CNT_W'(1)] <= '0;
                count                    <= count - CNT_W'(1);
            end
        end else if (char_valid && char_ready && (char_in != CW'(ASCII_NUL))) begin
            slots[count] <= char_in;
            count        <= count + CNT_W'(1);
        end
    end

    // The publish decision happens on the LOCK exit cycle itself, so the
    // strobe lands exactly LOCK_CYC cycles after the previous one; PUB is the
    // cycle in which that strobe is visible. A commit arriving on the very
    // cycle the timer hits zero is published rather than parked.
    always_comb begin
        state_n  = state;
        do_pub   = 1'b0;
        set_pend = 1'b0;
        case (state)
            IDLE: begin
                if (commit) begin
                    do_pub  = 1'b1;
                    state_n = LOCK;
                end
            end
            LOCK: begin
                if (lock_zero) begin
                    if (pend || commit) begin
                        do_pub  = 1'b1;
                        state_n = PUB;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    set_pend = commit;
                end
            end
            PUB: begin
                set_pend = commit;
                state_n  = LOCK;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            String <= '0;
            change <= 1'b0;
            pend   <= 1'b0;
        end else begin
            state  <= state_n;
            change <= do_pub;
            if (do_pub) begin
                String <= slots;
            end
            if (do_pub) begin
                pend <= 1'b0;
            end else if (set_pend) begin
                pend <= 1'b1;
            end
        end
    end

    lockout_timer #(
        .LOCK_CYC(LOCK_CYC)
    ) u_lockout_timer (
        .clk (clk),
        .rst (rst),
        .load(do_pub),
        .zero(lock_zero)
    );

endmodule

// File: tb/tb_string_loader.sv
// tb/tb_string_loader.sv - self-checking bench for string_loader
module tb_string_loader;

    localparam int N  = 11;
    localparam int W  = 7;
    localparam int L  = 32;
    localparam int SW = N * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          char_valid;
    logic [W-1:0]  char_in;
    logic          char_ready;
    logic          backspace;
    logic          clear;
    logic          commit;
    logic [SW-1:0] String;
    logic          change;
    logic [3:0]    count;
    logic          pend;

    string_loader #(
        .NCHARS  (N),
        .CW      (W),
        .LOCK_CYC(L)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .char_valid(char_valid),
        .char_in   (char_in),
        .char_ready(char_ready),
        .backspace (backspace),
        .clear     (clear),
        .commit    (commit),
        .String    (String),
        .change    (change),
        .count     (count),
        .pend      (pend)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int cyc      = 0;

    // Reference model: staged text as a queue, published word, pending flag,
    // and the cycle in which the last strobe was visible.
    byte unsigned  stg[$];
    logic [SW-1:0] m_str;
    bit            m_pend;
    int            m_last;
    int            chg_prev = 0;
    int            chg_last = 0;
    int            t0;

    function automatic logic [SW-1:0] pack_stg();
        logic [SW-1:0] s;
        s = '0;
        for (int i = 0; i < stg.size(); i++) begin
            s[SW-1-i*W -: W] = stg[i][W-1:0];
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [SW-1:0] got, input logic [SW-1:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step(input bit cv, input logic [W-1:0] ch, input bit bs, input bit clr, input bit cm);
        bit pub;
        char_valid = cv;
        char_in    = ch;
        backspace  = bs;
        clear      = clr;
        commit     = cm;
        #1;
        chk("char_ready", char_ready, stg.size() < N);
        // A publish may land no sooner than L cycles after the previous one.
        pub = (cm || m_pend) && (cyc >= m_last + L - 1);
        if (pub) begin
            m_str  = pack_stg();
            m_last = cyc + 1;
            m_pend = 1'b0;
        end else if (cm) begin
            m_pend = 1'b1;
        end
        if (clr) begin
            stg.delete();
        end else if (bs) begin
            if (stg.size() > 0) void'(stg.pop_back());
        end else if (cv && stg.size() < N && ch != 0) begin
            stg.push_back(byte'(ch));
        end
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("change", change, pub);
        chk("String", String, m_str);
        chk("count", count, stg.size());
        chk("pend", pend, m_pend);
        if (change) begin
            chg_prev = chg_last;
            chg_last = cyc;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        char_valid = 1'b0;
        char_in    = '0;
        backspace  = 1'b0;
        clear      = 1'b0;
        commit     = 1'b0;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst = 1'b0;
        stg.delete();
        m_str  = '0;
        m_pend = 1'b0;
        m_last = -1000;
        chk("rst_String", String, '0);
        chk("rst_change", change, 1'b0);
        chk("rst_count", count, 0);
        chk("rst_pend", pend, 1'b0);
        chk("rst_ready", char_ready, 1'b1);
    endtask

    initial begin
        bit            cv, bs, clr, cm;
        logic [W-1:0]  ch;

        @(negedge clk);
        do_reset();

        // Two characters then commit: published on the next cycle.
        step(1, 7'h48, 0, 0, 0);
        step(1, 7'h49, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        chk("t1_str", String, {7'h48, 7'h49, 63'b0});
        chk("t1_chg", change, 1'b1);
        chk("t1_cnt", count, 2);
        step(0, '0, 0, 0, 0);
        chk("t1_chg_once", change, 1'b0);
        idle(40);

        // Overfill: the twelfth character is refused.
        step(0, '0, 0, 1, 0);
        for (int i = 0; i < 12; i++) step(1, 7'h41, 0, 0, 0);
        chk("t2_ready", char_ready, 1'b0);
        chk("t2_cnt", count, 11);
        step(0, '0, 0, 0, 1);
        chk("t2_str", String, {11{7'h41}});
        idle(40);

        // Backspace edits, and backspace on an empty buffer.
        step(0, '0, 0, 1, 0);
        step(1, 7'h41, 0, 0, 0);
        step(1, 7'h42, 0, 0, 0);
        step(0, '0, 1, 0, 0);
        step(1, 7'h43, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        chk("t3_str", String, {7'h41, 7'h43, 63'b0});
        step(0, '0, 0, 1, 0);
        step(0, '0, 1, 0, 0);
        chk("t3_bs_empty", count, 0);
        idle(40);

        // Second commit 10 cycles after the first is held until lockout ends.
        step(0, '0, 0, 0, 1);
        t0 = chg_last;
        idle(9);
        step(0, '0, 0, 0, 1);
        chk("t4_pend", pend, 1'b1);
        idle(10);
        step(1, 7'h5A, 0, 0, 0);
        idle(20);
        chk("t4_spacing", chg_last - t0, L);
        chk("t4_str", String, {7'h5A, 70'b0});
        idle(40);

        // Same-cycle clear + char + commit publishes the pre-edit text.
        step(0, '0, 0, 1, 0);
        step(1, 7'h58, 0, 0, 0);
        step(1, 7'h59, 0, 0, 0);
        step(1, 7'h5A, 0, 1, 1);
        chk("t5_str", String, {7'h58, 7'h59, 63'b0});
        chk("t5_cnt", count, 0);
        step(1, 7'h00, 0, 0, 0);
        chk("t5_nul", count, 0);
        idle(40);

        // Reset with a pending commit discards it.
        step(1, 7'h31, 0, 0, 1);
        step(0, '0, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        chk("t6_pend", pend, 1'b1);
        do_reset();
        idle(40);
        step(1, 7'h32, 0, 0, 0);
        step(0, '0, 0, 0, 1);
        chk("t6_immediate", change, 1'b1);
        chk("t6_str", String, {7'h32, 70'b0});

        // Random traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                cv  = ($urandom_range(0, 1) == 1);
                ch  = ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom_range(1, 127));
                bs  = ($urandom_range(0, 11) == 0);
                clr = ($urandom_range(0, 39) == 0);
                cm  = ($urandom_range(0, 14) == 0);
                step(cv, ch, bs, clr, cm);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
